// File: rtl/memory_cycle.sv
// MEM stage of the 18-bit pipeline: data-memory req/ready handshake, stall generation
// toward the hazard unit, and the MEM/WB pipeline register feeding writeback/forwarding.
`timescale 1ns / 1ps

module memory_cycle #(
   parameter int unsigned DATA_W   = 18,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RegWriteM,
   input  logic              MemWriteM,
   input  logic              ResultSrcM,
   input  logic [4:0]        RD_M,
   input  logic [DATA_W-1:0] PCPlus4M,
   input  logic [DATA_W-1:0] ALU_ResultM,
   input  logic [DATA_W-1:0] WriteDataM,
   input  logic [1:0]        RGB_M,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              StallM,
   output logic              ErrM,
   output logic              RegWriteW,
   output logic [4:0]        RD_W,
   output logic [DATA_W-1:0] PCPlus4W,
   output logic [DATA_W-1:0] ResultW,
   output logic [1:0]        RGB_W
);

   localparam int unsigned CntW = ($clog2(MAX_WAIT + 1) < 1) ? 1 : $clog2(MAX_WAIT + 1);

   typedef enum logic [0:0] {StIdle, StAccess} state_t;

   state_t              r_state, w_state_next;
   logic                w_memop, w_stall, w_start, w_done, w_timeout;
   logic [CntW-1:0]     r_cnt;
   logic                r_mem_req, r_mem_we, r_err;
   logic [DATA_W-1:0]   r_mem_addr, r_mem_wdata;

   // MEM/WB pipeline register fields
   logic                r_reg_write_w, r_result_src_w;
   logic [4:0]          r_rd_w;
   logic [1:0]          r_rgb_w;
   logic [DATA_W-1:0]   r_pc_plus4_w, r_alu_result_w, r_read_data_w;

   // A load-store pair (both bits set) is issued as a store
   assign w_memop = MemWriteM | ResultSrcM;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= StIdle;
      else      r_state <= w_state_next;
   end

   // Next-state, stall and completion decode
   always_comb begin
      w_state_next = r_state;
      w_stall      = 1'b0;
      w_start      = 1'b0;
      w_done       = 1'b0;
      w_timeout    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_memop) begin
               w_stall      = 1'b1;
               w_start      = 1'b1;
               w_state_next = StAccess;
            end
         end
         StAccess: begin
            if (mem_ready) begin
               w_done       = 1'b1;
               w_state_next = StIdle;
            end else if (r_cnt == CntW'(MAX_WAIT)) begin
               // Forced completion: behaves like ready with zero read data
               w_done       = 1'b1;
               w_timeout    = 1'b1;
               w_state_next = StIdle;
            end else begin
               w_stall = 1'b1;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Memory request registers, wait counter and sticky timeout flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cnt       <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_start) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= MemWriteM;
            r_mem_addr  <= ALU_ResultM;
            r_mem_wdata <= WriteDataM;
            r_cnt       <= '0;
         end else if (w_done) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
         end else if (r_state == StAccess) begin
            r_cnt <= r_cnt + CntW'(1);
         end
         if (w_timeout) r_err <= 1'b1;
      end
   end

   // MEM/WB register: bubble while stalled, otherwise the M-stage fields
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_reg_write_w  <= 1'b0;
         r_result_src_w <= 1'b0;
         r_rd_w         <= '0;
         r_rgb_w        <= '0;
         r_pc_plus4_w   <= '0;
         r_alu_result_w <= '0;
         r_read_data_w  <= '0;
      end else if (w_stall) begin
         r_reg_write_w  <= 1'b0;
         r_result_src_w <= 1'b0;
         r_rd_w         <= '0;
         r_rgb_w        <= '0;
         r_pc_plus4_w   <= '0;
         r_alu_result_w <= '0;
         r_read_data_w  <= '0;
      end else begin
         r_reg_write_w  <= RegWriteM;
         r_result_src_w <= ResultSrcM;
         r_rd_w         <= RD_M;
         r_rgb_w        <= RGB_M;
         r_pc_plus4_w   <= PCPlus4M;
         r_alu_result_w <= ALU_ResultM;
         // Stores and timeouts write back zero read data
         r_read_data_w  <= (w_done && !r_mem_we && !w_timeout) ? mem_rdata : '0;
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign ErrM      = r_err;
   // Held low during reset even if a memory op is sitting in M
   assign StallM    = w_stall & rst;
   assign RegWriteW = r_reg_write_w;
   assign RD_W      = r_rd_w;
   assign PCPlus4W  = r_pc_plus4_w;
   assign RGB_W     = r_rgb_w;
   assign ResultW   = r_result_src_w ? r_read_data_w : r_alu_result_w;

endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: vector table plus hand sequences; WB results checked via a queue.
`timescale 1ns / 1ps

module tb_memory_cycle;

   typedef struct {
      logic        rw, mw, rs;
      logic [4:0]  rd;
      logic [17:0] pc, alu, wd;
      logic [1:0]  rgb;
   } m_t;

   typedef struct {
      logic        bub;
      logic        rw;
      logic [4:0]  rd;
      logic [17:0] pc, res;
      logic [1:0]  rgb;
   } wb_t;

   typedef struct {
      m_t          m;
      logic        ready;
      logic [17:0] rdata;
      logic        stall, req, we, err;
      wb_t         wb;
   } vec_t;

   logic        clk, rst;
   logic        RegWriteM, MemWriteM, ResultSrcM;
   logic [4:0]  RD_M;
   logic [17:0] PCPlus4M, ALU_ResultM, WriteDataM;
   logic [1:0]  RGB_M;
   logic        mem_req, mem_we;
   logic [17:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready, StallM, ErrM, RegWriteW;
   logic [4:0]  RD_W;
   logic [17:0] PCPlus4W, ResultW;
   logic [1:0]  RGB_W;

   int n_checks = 0;
   int n_fail   = 0;
   wb_t sb_q[$];
   vec_t tbl[$];

   memory_cycle #(.DATA_W(18), .MAX_WAIT(15)) dut (
      .clk(clk), .rst(rst),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .RD_M(RD_M), .PCPlus4M(PCPlus4M), .ALU_ResultM(ALU_ResultM),
      .WriteDataM(WriteDataM), .RGB_M(RGB_M),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .StallM(StallM), .ErrM(ErrM), .RegWriteW(RegWriteW), .RD_W(RD_W),
      .PCPlus4W(PCPlus4W), .ResultW(ResultW), .RGB_W(RGB_W)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   function automatic m_t alu_op(input logic rw, input logic [4:0] rd, input logic [17:0] pc,
                                 input logic [17:0] alu, input logic [1:0] rgb);
      m_t m;
      m.rw = rw; m.mw = 1'b0; m.rs = 1'b0; m.rd = rd;
      m.pc = pc; m.alu = alu; m.wd = 18'h0; m.rgb = rgb;
      return m;
   endfunction

   function automatic m_t ld_op(input logic [4:0] rd, input logic [17:0] pc,
                                input logic [17:0] addr, input logic [1:0] rgb);
      m_t m;
      m.rw = 1'b1; m.mw = 1'b0; m.rs = 1'b1; m.rd = rd;
      m.pc = pc; m.alu = addr; m.wd = 18'h0; m.rgb = rgb;
      return m;
   endfunction

   function automatic m_t st_op(input logic [17:0] pc, input logic [17:0] addr,
                                input logic [17:0] wd, input logic rs);
      m_t m;
      m.rw = 1'b0; m.mw = 1'b1; m.rs = rs; m.rd = 5'd3;
      m.pc = pc; m.alu = addr; m.wd = wd; m.rgb = 2'd0;
      return m;
   endfunction

   function automatic wb_t wb_bub();
      wb_t w;
      w.bub = 1'b1; w.rw = 1'b0; w.rd = 5'd0; w.pc = 18'h0; w.res = 18'h0; w.rgb = 2'd0;
      return w;
   endfunction

   function automatic wb_t wb_of(input logic rw, input logic [4:0] rd, input logic [17:0] pc,
                                 input logic [17:0] res, input logic [1:0] rgb);
      wb_t w;
      w.bub = 1'b0; w.rw = rw; w.rd = rd; w.pc = pc; w.res = res; w.rgb = rgb;
      return w;
   endfunction

   function automatic vec_t mk(input m_t m, input logic ready, input logic [17:0] rdata,
                               input logic stall, input logic req, input logic we,
                               input logic err, input wb_t wb);
      vec_t v;
      v.m = m; v.ready = ready; v.rdata = rdata;
      v.stall = stall; v.req = req; v.we = we; v.err = err; v.wb = wb;
      return v;
   endfunction

   task automatic drive_m(input m_t m);
      RegWriteM = m.rw; MemWriteM = m.mw; ResultSrcM = m.rs; RD_M = m.rd;
      PCPlus4M = m.pc; ALU_ResultM = m.alu; WriteDataM = m.wd; RGB_M = m.rgb;
   endtask

   task automatic pop_wb(input string tag);
      wb_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s.wb_queue: got empty queue, required a pending entry", tag);
      end else begin
         e = sb_q.pop_front();
         check({tag, ".RegWriteW"}, 32'(RegWriteW), 32'(e.rw));
         check({tag, ".RD_W"}, 32'(RD_W), 32'(e.rd));
         check({tag, ".RGB_W"}, 32'(RGB_W), 32'(e.rgb));
         if (!e.bub) begin
            check({tag, ".PCPlus4W"}, 32'(PCPlus4W), 32'(e.pc));
            check({tag, ".ResultW"}, 32'(ResultW), 32'(e.res));
         end
      end
   endtask

   // Called at posedge+1: drive, settle, compare, push next WB expectation, advance
   task automatic apply(input string tag, input vec_t v);
      drive_m(v.m);
      mem_ready = v.ready;
      mem_rdata = v.rdata;
      #1;
      check({tag, ".StallM"}, 32'(StallM), 32'(v.stall));
      check({tag, ".mem_req"}, 32'(mem_req), 32'(v.req));
      check({tag, ".mem_we"}, 32'(mem_we), 32'(v.we));
      check({tag, ".ErrM"}, 32'(ErrM), 32'(v.err));
      if (v.req) begin
         check({tag, ".mem_addr"}, 32'(mem_addr), 32'(v.m.alu));
         if (v.we) check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(v.m.wd));
      end
      pop_wb(tag);
      sb_q.push_back(v.wb);
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".mem_req"}, 32'(mem_req), 32'h0);
      check({tag, ".mem_we"}, 32'(mem_we), 32'h0);
      check({tag, ".mem_addr"}, 32'(mem_addr), 32'h0);
      check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'h0);
      check({tag, ".StallM"}, 32'(StallM), 32'h0);
      check({tag, ".ErrM"}, 32'(ErrM), 32'h0);
      check({tag, ".RegWriteW"}, 32'(RegWriteW), 32'h0);
      check({tag, ".RD_W"}, 32'(RD_W), 32'h0);
      check({tag, ".PCPlus4W"}, 32'(PCPlus4W), 32'h0);
      check({tag, ".ResultW"}, 32'(ResultW), 32'h0);
      check({tag, ".RGB_W"}, 32'(RGB_W), 32'h0);
   endtask

   initial begin
      m_t a_op, l1, l2, b_op, s1, s2, c_op, s3, l4, d_op, l6, e_op, f_op;

      a_op = alu_op(1'b1, 5'd5, 18'h00004, 18'h00123, 2'd1);
      l1   = ld_op(5'd7, 18'h00008, 18'h00040, 2'd2);
      l2   = ld_op(5'd12, 18'h00010, 18'h00044, 2'd1);
      b_op = alu_op(1'b1, 5'd13, 18'h00014, 18'h2AAAA, 2'd0);
      s1   = st_op(18'h00018, 18'h00050, 18'h0BEEF, 1'b0);
      s2   = st_op(18'h0001C, 18'h00054, 18'h0CAFE, 1'b1);
      c_op = alu_op(1'b0, 5'd0, 18'h00020, 18'h3FFFF, 2'd2);
      s3   = st_op(18'h00024, 18'h00008, 18'h01111, 1'b0);
      l4   = ld_op(5'd9, 18'h00028, 18'h00100, 2'd1);
      d_op = alu_op(1'b1, 5'd20, 18'h0002C, 18'h00ABC, 2'd3);
      l6   = ld_op(5'd14, 18'h00030, 18'h00200, 2'd3);
      e_op = alu_op(1'b1, 5'd21, 18'h00034, 18'h00555, 2'd1);
      f_op = alu_op(1'b1, 5'd22, 18'h00038, 18'h01234, 2'd2);

      // ALU op, load ready at once, load + ALU + store + load-store, ALU with stray ready
      tbl.push_back(mk(a_op, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                       wb_of(1'b1, 5'd5, 18'h00004, 18'h00123, 2'd1)));
      tbl.push_back(mk(l1, 1'b0, 18'h0, 1'b1, 1'b0, 1'b0, 1'b0, wb_bub()));
      tbl.push_back(mk(l1, 1'b1, 18'h3ABCD, 1'b0, 1'b1, 1'b0, 1'b0,
                       wb_of(1'b1, 5'd7, 18'h00008, 18'h3ABCD, 2'd2)));
      tbl.push_back(mk(l2, 1'b0, 18'h0, 1'b1, 1'b0, 1'b0, 1'b0, wb_bub()));
      tbl.push_back(mk(l2, 1'b1, 18'h00777, 1'b0, 1'b1, 1'b0, 1'b0,
                       wb_of(1'b1, 5'd12, 18'h00010, 18'h00777, 2'd1)));
      tbl.push_back(mk(b_op, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                       wb_of(1'b1, 5'd13, 18'h00014, 18'h2AAAA, 2'd0)));
      tbl.push_back(mk(s1, 1'b0, 18'h0, 1'b1, 1'b0, 1'b0, 1'b0, wb_bub()));
      tbl.push_back(mk(s1, 1'b1, 18'h12345, 1'b0, 1'b1, 1'b1, 1'b0,
                       wb_of(1'b0, 5'd3, 18'h00018, 18'h00050, 2'd0)));
      tbl.push_back(mk(s2, 1'b0, 18'h0, 1'b1, 1'b0, 1'b0, 1'b0, wb_bub()));
      tbl.push_back(mk(s2, 1'b1, 18'h15555, 1'b0, 1'b1, 1'b1, 1'b0,
                       wb_of(1'b0, 5'd3, 18'h0001C, 18'h00000, 2'd0)));
      tbl.push_back(mk(c_op, 1'b1, 18'h2F0F0, 1'b0, 1'b0, 1'b0, 1'b0,
                       wb_of(1'b0, 5'd0, 18'h00020, 18'h3FFFF, 2'd2)));

      // Reset with an ALU op already presented
      rst = 1'b0;
      drive_m(a_op);
      mem_ready = 1'b0;
      mem_rdata = 18'h0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b1;
      sb_q.push_back(wb_of(1'b0, 5'd0, 18'h0, 18'h0, 2'd0));

      for (int i = 0; i < tbl.size(); i++) apply($sformatf("tbl%0d", i), tbl[i]);

      // Store with three wait cycles: request fields held for four cycles
      apply("st_idle", mk(s3, 1'b0, 18'h0, 1'b1, 1'b0, 1'b0, 1'b0, wb_bub()));
      for (int i = 0; i < 3; i++)
         apply($sformatf("st_wait%0d", i), mk(s3, 1'b0, 18'h0, 1'b1, 1'b1, 1'b1, 1'b0, wb_bub()));
      apply("st_done", mk(s3, 1'b1, 18'h02222, 1'b0, 1'b1, 1'b1, 1'b0,
                          wb_of(1'b0, 5'd3, 18'h00024, 18'h00008, 2'd0)));

      // Load that never sees ready: 1 + 15 stall cycles, then forced completion
      apply("to_idle", mk(l4, 1'b0, 18'h0, 1'b1, 1'b0, 1'b0, 1'b0, wb_bub()));
      for (int i = 0; i < 15; i++)
         apply($sformatf("to_wait%0d", i), mk(l4, 1'b0, 18'h1FFFF, 1'b1, 1'b1, 1'b0, 1'b0,
                                             wb_bub()));
      apply("to_done", mk(l4, 1'b0, 18'h1FFFF, 1'b0, 1'b1, 1'b0, 1'b0,
                          wb_of(1'b1, 5'd9, 18'h00028, 18'h00000, 2'd1)));
      apply("to_late", mk(d_op, 1'b1, 18'h3FFFF, 1'b0, 1'b0, 1'b0, 1'b1,
                          wb_of(1'b1, 5'd20, 18'h0002C, 18'h00ABC, 2'd3)));
      apply("to_after", mk(e_op, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b1,
                           wb_of(1'b1, 5'd21, 18'h00034, 18'h00555, 2'd1)));

      // Reset in the middle of an access
      apply("rs_idle", mk(l6, 1'b0, 18'h0, 1'b1, 1'b0, 1'b0, 1'b1, wb_bub()));
      apply("rs_wait0", mk(l6, 1'b0, 18'h0, 1'b1, 1'b1, 1'b0, 1'b1, wb_bub()));
      apply("rs_wait1", mk(l6, 1'b0, 18'h0, 1'b1, 1'b1, 1'b0, 1'b1, wb_bub()));
      rst = 1'b0;
      #1;
      check_all_zero("rs_assert");
      drive_m(e_op);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      sb_q.delete();
      sb_q.push_back(wb_of(1'b0, 5'd0, 18'h0, 18'h0, 2'd0));
      apply("rs_alu0", mk(e_op, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                          wb_of(1'b1, 5'd21, 18'h00034, 18'h00555, 2'd1)));
      apply("rs_alu1", mk(f_op, 1'b1, 18'h0AAAA, 1'b0, 1'b0, 1'b0, 1'b0,
                          wb_of(1'b1, 5'd22, 18'h00038, 18'h01234, 2'd2)));
      pop_wb("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- MEM stage of the 18-bit pipeline; consumes the EX/MEM register outputs produced by the execute stage.
- Runs a req/ready handshake to an external multi-cycle data memory and asserts a stall toward the hazard unit while an access is outstanding.
- Holds the MEM/WB pipeline register and drives ResultW back to the execute-stage forwarding muxes.

Parameters:
- DATA_W, 18, data/address width
- MAX_WAIT, 15, max ACCESS cycles without mem_ready before forced completion

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- RegWriteM  in  1  register-write enable of instruction in M
- MemWriteM  in  1  store
- ResultSrcM  in  1  load / select memory data for writeback
- RD_M  in  5  destination register
- PCPlus4M  in  18  PC+4 of instruction in M
- ALU_ResultM  in  18  address or ALU result
- WriteDataM  in  18  store data
- RGB_M  in  2  RGB tag from EX
- mem_req  out  1  memory request
- mem_we  out  1  write strobe, valid with mem_req
- mem_addr  out  18  address
- mem_wdata  out  18  store data
- mem_rdata  in  18  load data, valid with mem_ready
- mem_ready  in  1  access complete
- StallM  out  1  freeze PC/IF/ID/EX and EX/MEM
- ErrM  out  1  sticky timeout flag
- RegWriteW  out  1  MEM/WB register-write
- RD_W  out  5  MEM/WB destination
- PCPlus4W  out  18  MEM/WB PC+4
- ResultW  out  18  ResultSrcW ? ReadDataW : ALU_ResultW
- RGB_W  out  2  MEM/WB RGB tag

Behaviour:
- memop = MemWriteM | ResultSrcM. If both are set, the access is a store (mem_we=1); ResultSrcM still selects writeback data.
- FSM states: IDLE, ACCESS.
- IDLE, memop=0: StallM=0. MEM/WB loads M fields every edge; ReadDataW<=0.
- IDLE, memop=1: StallM=1. MEM/WB loads a bubble (RegWriteW=0, RD_W=0, RGB_W=0). At the edge, latch mem_addr=ALU_ResultM, mem_wdata=WriteDataM, mem_we=MemWriteM; go to ACCESS; clear the wait counter.
- ACCESS: mem_req=1 (registered), address/data stable.
  - mem_ready=0: StallM=1, bubble into MEM/WB, counter++.
  - mem_ready=1: StallM=0 in the same cycle (combinational). At the edge, MEM/WB loads M fields plus ReadDataW=mem_rdata (stores load 0); mem_req<=0; go to IDLE.
- Outside ACCESS, mem_req=0 and mem_we=0.
- Latency: non-memory ops add 0 stall cycles. A memory op stalls 1 + N cycles, where N = cycles in ACCESS before ready (minimum total 1 stall cycle when ready arrives in the first ACCESS cycle).
- Back-to-back memory ops: each returns through IDLE, so one IDLE stall cycle is inserted per op.
- Timeout: counter reaches MAX_WAIT in ACCESS with no ready.
  - Treat as ready with mem_rdata forced to 0.
  - Set ErrM=1 (sticky until reset).
  - Return to IDLE.
  - A late mem_ready in IDLE is ignored.
- StallM=0 at all times except the cases listed above; it never blocks a non-memory instruction.
- ResultW is combinational from the MEM/WB register only; no path from the M inputs.
- Reset (async, any state including mid-ACCESS):
  - state=IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, StallM, ErrM = 0.
  - All MEM/WB fields 0, so RegWriteW=0 and ResultW=0.
  - After release, an in-flight access is abandoned, not replayed.

Test Plan:
1. Reset low, then high with ALU op (RegWriteM=1, RD_M=5, ALU_ResultM=0x00123) -> all outputs 0 during reset; one edge later RegWriteW=1, RD_W=5, ResultW=0x00123, StallM=0.
2. Load at addr 0x00040, memory ready on first ACCESS cycle with rdata 0x3ABCD -> StallM high exactly 1 cycle; mem_req high 1 cycle, mem_we=0; then ResultW=0x3ABCD, RD_W correct, bubble (RegWriteW=0) in the preceding WB cycle.
3. Store 0x01111 to 0x00008, ready after 3 wait cycles -> mem_we=1, mem_addr=0x00008, mem_wdata=0x01111 stable for 4 cycles; StallM high 4 cycles; RegWriteW follows RegWriteM (0).
4. Load with mem_ready never asserted, MAX_WAIT=15 -> StallM released after 1+15 cycles; ErrM=1 and stays 1; ResultW=0; late ready ignored.
5. Load followed by an ALU op and then a store, each with ready in 1 cycle -> ALU op passes with no stall; each memory op costs exactly 1 stall cycle; WB order preserved.
6. rst asserted in ACCESS mid-wait -> mem_req drops immediately; after release state is IDLE, ErrM=0, StallM=0 with a non-memory op in M.
